// File: rtl/tdm_pkg.sv
// Shared types and default geometry for the TDM slot scheduler.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SLOT_W_DEF  = 3;
  localparam int PHASE_W_DEF = 2;

endpackage

// File: rtl/tdm_frame_cnt.sv
// Phase/slot counter for one TDM frame; reports the last phase and last slot.
module tdm_frame_cnt
  import tdm_pkg::*;
#(
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               clear,
  output logic [SLOT_W-1:0]  slot_idx,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_last,
  output logic               slot_last
);

  assign phase_last = &phase;
  assign slot_last  = &slot_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_idx <= '0;
      phase    <= '0;
    end else if (clear) begin
      slot_idx <= '0;
      phase    <= '0;
    end else if (run) begin
      phase <= phase + 1'b1;
      if (phase_last) slot_idx <= slot_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_slot_sched.sv
// TDM slot scheduler: per-channel slot table with frame-aligned config commit.
// Define TDM_GUARD_EN to drop ch_active in the last phase of every slot.
module tdm_slot_sched
  import tdm_pkg::*;
#(
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int NUM_CH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      one_shot,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [SLOT_W-1:0]         cfg_slot,
  input  logic                      cfg_act,
  output logic [SLOT_W-1:0]         slot_idx,
  output logic [PHASE_W-1:0]        phase,
  output logic                      frame_start,
  output logic [NUM_CH-1:0]         ch_active,
  output logic                      done
);

  state_t                      state;
  logic                        running;
  logic                        phase_last;
  logic                        slot_last;
  logic                        frame_last;
  logic                        stop;
  logic                        cnt_clear;
  logic                        commit;
  logic                        window_ok;

  logic                        pend_v;
  logic [$clog2(NUM_CH)-1:0]   pend_ch;
  logic [SLOT_W-1:0]           pend_slot;
  logic                        pend_act;
  logic [SLOT_W-1:0]           slot_tab [NUM_CH];
  logic [NUM_CH-1:0]           act_tab;

  tdm_frame_cnt #(
    .SLOT_W  (SLOT_W),
    .PHASE_W (PHASE_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .run        (running),
    .clear      (cnt_clear),
    .slot_idx   (slot_idx),
    .phase      (phase),
    .phase_last (phase_last),
    .slot_last  (slot_last)
  );

  assign running    = (state == RUN);
  assign frame_last = running && phase_last && slot_last;
  assign stop       = !en || (one_shot && frame_last);
  assign cnt_clear  = !running || stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (en)   state <= RUN;
        RUN:  if (stop) state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // Commit on the edge that leaves the last cycle of a frame, so the new
  // table is already in place for slot 0 / phase 0 of the next frame.
  assign commit = pend_v && (!running || frame_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b1;
      pend_v    <= 1'b0;
      pend_ch   <= '0;
      pend_slot <= '0;
      pend_act  <= 1'b0;
      act_tab   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) slot_tab[c] <= '0;
    end else if (commit) begin
      slot_tab[pend_ch] <= pend_slot;
      act_tab[pend_ch]  <= pend_act;
      pend_v            <= 1'b0;
      cfg_ready         <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      pend_ch   <= cfg_ch;
      pend_slot <= cfg_slot;
      pend_act  <= cfg_act;
      pend_v    <= 1'b1;
      cfg_ready <= 1'b0;
    end
  end

`ifdef TDM_GUARD_EN
  assign window_ok = !phase_last;
`else
  assign window_ok = 1'b1;
`endif

  // Status decodes of registered state so done lands in the final frame cycle.
  assign frame_start = running && (slot_idx == '0) && (phase == '0);
  assign done        = one_shot && frame_last;

  always_comb begin
    ch_active = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      ch_active[c] = running && act_tab[c] && (slot_tab[c] == slot_idx) && window_ok;
  end

endmodule

// File: tb/tb_tdm_slot_sched.sv
// Directed bench for tdm_slot_sched with default geometry (8 slots x 4 phases).
module tb_tdm_slot_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       one_shot = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [2:0] cfg_slot = '0;
  logic       cfg_act = 1'b0;
  logic [2:0] slot_idx;
  logic [1:0] phase;
  logic       frame_start;
  logic [3:0] ch_active;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] m_slot [4];
  logic [3:0] m_act;

  always #5 clk = ~clk;

  tdm_slot_sched #(
    .SLOT_W  (3),
    .PHASE_W (2),
    .NUM_CH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .one_shot    (one_shot),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_slot    (cfg_slot),
    .cfg_act     (cfg_act),
    .slot_idx    (slot_idx),
    .phase       (phase),
    .frame_start (frame_start),
    .ch_active   (ch_active),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for frame cycle k of a running schedule.
  task automatic frame_check(input int k);
    int         ki;
    logic [3:0] ea;
    logic       guard_ok;
    ki = k % 32;
`ifdef TDM_GUARD_EN
    guard_ok = ((ki % 4) != 3);
`else
    guard_ok = 1'b1;
`endif
    for (int c = 0; c < 4; c++)
      ea[c] = m_act[c] && (m_slot[c] == 3'(ki / 4)) && guard_ok;
    check("slot_idx", 32'(slot_idx), ki / 4);
    check("phase", 32'(phase), ki % 4);
    check("frame_start", 32'(frame_start), (ki == 0) ? 1 : 0);
    check("ch_active", 32'(ch_active), 32'(ea));
    check("done", 32'(done), (one_shot && ki == 31) ? 1 : 0);
  endtask

  task automatic idle_check();
    check("idle_slot", 32'(slot_idx), 0);
    check("idle_phase", 32'(phase), 0);
    check("idle_frame_start", 32'(frame_start), 0);
    check("idle_ch_active", 32'(ch_active), 0);
    check("idle_done", 32'(done), 0);
  endtask

  // Program one channel while idle; returns after the commit is visible.
  task automatic cfg_write(input logic [1:0] ch, input logic [2:0] slot, input logic act);
    int n;
    @(negedge clk);
    cfg_ch = ch; cfg_slot = slot; cfg_act = act; cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("cfg_accept_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_ready_low", 32'(cfg_ready), 0);
    @(negedge clk);
    check("cfg_ready_back", 32'(cfg_ready), 1);
    m_slot[ch] = slot;
    m_act[ch]  = act;
  endtask

  initial begin
    m_act = '0;
    for (int c = 0; c < 4; c++) m_slot[c] = '0;

    #12;
    idle_check();
    check("reset_cfg_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // ch0 -> slot 2, two continuous frames
    cfg_write(2'd0, 3'd2, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      frame_check(k);
    end
    en = 1'b0;
    @(negedge clk);
    idle_check();

    // ch0 and ch3 share slot 4
    cfg_write(2'd3, 3'd4, 1'b1);
    cfg_write(2'd0, 3'd4, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      frame_check(k);
    end
    en = 1'b0;
    @(negedge clk);
    idle_check();

    // one-shot frame with en held high: must stop after cycle 31
    cfg_write(2'd1, 3'd1, 1'b1);
    one_shot = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      frame_check(k);
    end
    @(negedge clk);
    idle_check();
    en = 1'b0;
    one_shot = 1'b0;

    // mid-frame reprogram of ch1, then reset at slot 3 phase 2 with a pending entry
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= 78; k++) begin
      @(negedge clk);
      frame_check(k);
      if (k >= 21 && k <= 31) check("ready_pending", 32'(cfg_ready), 0);
      if (k == 20) begin
        cfg_ch = 2'd1; cfg_slot = 3'd6; cfg_act = 1'b1; cfg_valid = 1'b1;
      end
      if (k == 21) cfg_valid = 1'b0;
      if (k == 31) m_slot[1] = 3'd6;
      if (k == 32) check("ready_commit", 32'(cfg_ready), 1);
      if (k == 77) begin
        cfg_ch = 2'd2; cfg_slot = 3'd3; cfg_act = 1'b1; cfg_valid = 1'b1;
      end
      if (k == 78) begin
        cfg_valid = 1'b0;
        check("ready_pending2", 32'(cfg_ready), 0);
      end
    end
    rst = 1'b0;
    en = 1'b0;
    #1;
    idle_check();
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    m_act = '0;
    for (int c = 0; c < 4; c++) m_slot[c] = '0;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      frame_check(k);
    end
    en = 1'b0;
    @(negedge clk);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
